// File: rtl/playback_pkg.sv
// Shared types and widths for the note playback / note input checker pair.
package playback_pkg;

  localparam int unsigned NOTE_W    = 4;
  localparam int unsigned MAX_NOTES = 4;
  localparam int unsigned LEVEL_W   = 16;
  localparam int unsigned LEN_W     = 4;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    WAIT_RELEASE,
    PASS,
    FAIL
  } state_e;

  // Clamp a requested level length to the number of notes the level word holds.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(MAX_NOTES)) begin
      return LEN_W'(MAX_NOTES);
    end
    return len;
  endfunction

endpackage

// File: rtl/note_input_checker_if.sv
// Level / key inputs and pass-fail status of the note input checker.
interface note_input_checker_if;
  import playback_pkg::*;

  logic [LEVEL_W-1:0] level_data;
  logic [LEN_W-1:0]   level_length;
  logic               load_level;
  logic               start_input;
  logic [NOTE_W-1:0]  key;
  logic               busy;
  logic               input_done;
  logic               pass;
  logic               fail;
  logic [CNT_W-1:0]   notes_entered;
  logic [LEVEL_W-1:0] captured;

  modport master (
    output level_data, level_length, load_level, start_input, key,
    input  busy, input_done, pass, fail, notes_entered, captured
  );

  modport slave (
    input  level_data, level_length, load_level, start_input, key,
    output busy, input_done, pass, fail, notes_entered, captured
  );

endinterface

// File: rtl/input_timeout_timer.sv
// Reloadable down-counter that flags when the player took too long to press.
module input_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic reload_i,
  input  logic enable_i,
  output logic expired_c_o
);

  localparam int unsigned TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned RELOAD = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  logic [TMR_W-1:0] count_q;

  // Reload wins over counting; the counter parks at zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (reload_i) begin
      count_q <= TMR_W'(RELOAD);
    end else if (enable_i && (count_q != '0)) begin
      count_q <= count_q - TMR_W'(1);
    end
  end

  // A zero timeout disables expiry altogether.
  assign expired_c_o = (TIMEOUT_CYCLES != 0) && (count_q == '0);

endmodule

// File: rtl/note_input_checker.sv
// Captures player key presses and checks them against the loaded level word.
module note_input_checker
  import playback_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100
) (
  input logic                 clk,
  input logic                 reset,
  note_input_checker_if.slave bus_if
);

  state_e             state_q, state_d;
  logic [NOTE_W-1:0]  key_q;
  logic [LEVEL_W-1:0] lvl_q, lvl_d;
  logic [LEVEL_W-1:0] exp_q, exp_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEVEL_W-1:0] cap_q, cap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, done_q, pass_q, fail_q;
  logic               press_c, reload_c, busy_c, expired_c;
  logic [NOTE_W-1:0]  exp_note_c;

  assign press_c    = (bus_if.key != '0) && (key_q == '0);
  assign busy_c     = (state_q == ARMED) || (state_q == WAIT_RELEASE);
  assign exp_note_c = exp_q[LEVEL_W-1 -: NOTE_W];

  input_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .reload_i   (reload_c),
    .enable_i   (busy_c),
    .expired_c_o(expired_c)
  );

  // Next-state logic: load aborts everything, then arming, then press/timeout.
  always_comb begin
    state_d  = state_q;
    lvl_d    = lvl_q;
    exp_d    = exp_q;
    len_d    = len_q;
    cap_d    = cap_q;
    cnt_d    = cnt_q;
    reload_c = 1'b0;
    if (bus_if.load_level) begin
      lvl_d   = bus_if.level_data;
      exp_d   = bus_if.level_data;
      len_d   = clamp_len(bus_if.level_length);
      cap_d   = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, PASS, FAIL: begin
          if (bus_if.start_input) begin
            cap_d = '0;
            cnt_d = '0;
            if (len_q == '0) begin
              state_d = PASS;
            end else begin
              exp_d    = lvl_q;
              reload_c = 1'b1;
              state_d  = ARMED;
            end
          end
        end
        ARMED: begin
          if (press_c) begin
            cap_d    = {cap_q[LEVEL_W-NOTE_W-1:0], bus_if.key};
            cnt_d    = cnt_q + CNT_W'(1);
            reload_c = 1'b1;
            if (bus_if.key != exp_note_c) begin
              state_d = FAIL;
            end else if ((cnt_q + CNT_W'(1)) == CNT_W'(len_q)) begin
              state_d = PASS;
            end else begin
              exp_d   = exp_q << NOTE_W;
              state_d = WAIT_RELEASE;
            end
          end else if (expired_c) begin
            state_d = FAIL;
          end
        end
        WAIT_RELEASE: begin
          if (expired_c) begin
            state_d = FAIL;
          end else if (bus_if.key == '0) begin
            state_d = ARMED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, datapath and status registers; status is decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      lvl_q   <= '0;
      exp_q   <= '0;
      len_q   <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= bus_if.key;
      lvl_q   <= lvl_d;
      exp_q   <= exp_d;
      len_q   <= len_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == ARMED) || (state_d == WAIT_RELEASE);
      done_q  <= (state_d == PASS) || (state_d == FAIL);
      pass_q  <= (state_d == PASS);
      fail_q  <= (state_d == FAIL);
    end
  end

  assign bus_if.busy          = busy_q;
  assign bus_if.input_done    = done_q;
  assign bus_if.pass          = pass_q;
  assign bus_if.fail          = fail_q;
  assign bus_if.notes_entered = cnt_q;
  assign bus_if.captured      = cap_q;

endmodule
